// File: rtl/mem_burst_pkg.sv
// Shared widths, FSM state encoding and read-FIFO payload for the burst master.
package mem_burst_pkg;

  localparam int unsigned ADDR_W     = 9;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned LEN_W      = 4;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = 2;          // holds 0..FIFO_DEPTH
  localparam int unsigned OCC_W      = CNT_W + 1;  // occupancy + in-flight headroom

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    READ   = 2'd2,
    RDRAIN = 2'd3
  } state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } rd_beat_t;

endpackage

// File: rtl/mem_rd_fifo.sv
// Two-entry synchronous FIFO holding read beats ({last, data}) until the consumer takes them.
module mem_rd_fifo
  import mem_burst_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  rd_beat_t         push_beat,
  input  logic             pop,
  output rd_beat_t         head,
  output logic [CNT_W-1:0] count
);

  rd_beat_t entries [FIFO_DEPTH];
  // With two entries a single toggling bit is a complete pointer.
  logic     wr_ptr;
  logic     rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        entries[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= push_beat;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = entries[rd_ptr];

endmodule

// File: rtl/mem_burst_master.sv
// Burst initiator: turns (addr, len) requests into one memory access per cycle,
// feeding writes from the wr stream and returning reads on the rd stream.
module mem_burst_master
  import mem_burst_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_we,
  output logic              mem_burst_enable,
  output logic [LEN_W-1:0]  mem_burst_length,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_t            state;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat;
  logic              inflight;
  logic              inflight_last;
  logic              done_q;

  rd_beat_t          head;
  rd_beat_t          push_beat;
  logic [CNT_W-1:0]  count;
  logic [OCC_W-1:0]  occ_used;
  logic [ADDR_W-1:0] cur_addr;
  logic              wr_hs;
  logic              pop;
  logic              issue;
  logic              last_beat;

  assign cur_addr  = base_addr + ADDR_W'(beat);
  assign last_beat = (beat == len_q);
  assign wr_hs     = (state == WRITE) && wr_valid;
  assign pop       = rd_valid && rd_ready;

  // Occupancy after this cycle's pop plus the beat still coming back from memory;
  // counting the pop is what allows one read per cycle when the consumer keeps up.
  assign occ_used = OCC_W'(count) - OCC_W'(pop) + OCC_W'(inflight);
  assign issue    = (state == READ) && (occ_used < OCC_W'(FIFO_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      base_addr     <= '0;
      len_q         <= '0;
      beat          <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue && last_beat;
      case (state)
        IDLE: begin
          if (req_valid) begin
            base_addr <= req_addr;
            len_q     <= req_len;
            beat      <= '0;
            state     <= req_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_hs) begin
            if (last_beat) begin
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              beat <= beat + LEN_W'(1);
            end
          end
        end
        READ: begin
          if (issue) begin
            if (last_beat) begin
              state <= RDRAIN;
            end else begin
              beat <= beat + LEN_W'(1);
            end
          end
        end
        RDRAIN: begin
          if (pop && head.last) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory returns data one cycle after the address; capture it the cycle after issue.
  assign push_beat.last = inflight_last;
  assign push_beat.data = mem_data_out;

  mem_rd_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_beat (push_beat),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign req_ready        = (state == IDLE);
  assign wr_ready         = (state == WRITE);
  assign mem_we           = wr_hs;
  assign mem_addr         = ((state == WRITE) || (state == READ)) ? cur_addr : '0;
  assign mem_data_in      = (state == WRITE) ? wr_data : '0;
  assign rd_valid         = (count != '0);
  assign rd_data          = rd_valid ? head.data : '0;
  assign rd_last          = rd_valid && head.last;
  assign done             = done_q;
  assign mem_burst_enable = 1'b0;
  assign mem_burst_length = '0;

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a behavioural 512x32 memory and
// write/read scoreboards filled as stimulus is driven.
module tb_mem_burst_master;
  import mem_burst_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wr_valid, wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid, rd_ready, rd_last, done;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in, mem_data_out;
  logic              mem_we, mem_burst_enable;
  logic [LEN_W-1:0]  mem_burst_length;

  always #5 clk = ~clk;

  mem_burst_master dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_len          (req_len),
    .wr_valid         (wr_valid),
    .wr_ready         (wr_ready),
    .wr_data          (wr_data),
    .rd_valid         (rd_valid),
    .rd_ready         (rd_ready),
    .rd_data          (rd_data),
    .rd_last          (rd_last),
    .done             (done),
    .mem_addr         (mem_addr),
    .mem_data_in      (mem_data_in),
    .mem_we           (mem_we),
    .mem_burst_enable (mem_burst_enable),
    .mem_burst_length (mem_burst_length),
    .mem_data_out     (mem_data_out)
  );

  // Single-port memory with registered read data
  logic [DATA_W-1:0] mem [512];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data_in;
    mem_data_out <= mem[mem_addr];
  end

  typedef struct packed {logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;} wr_exp_t;
  typedef struct packed {logic last; logic [DATA_W-1:0] data;} rd_exp_t;

  wr_exp_t           exp_wq[$];
  rd_exp_t           exp_rq[$];
  logic [DATA_W-1:0] ref_mem [512];

  int n_checks = 0, n_errors = 0;
  int we_count = 0, done_count = 0, pop_count = 0;
  int win = 0, first_win = -1, last_win = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, scoreboard compare, then advance past the rising edge.
  task automatic cycle();
    wr_exp_t we_e;
    rd_exp_t re_e;
    @(negedge clk);
    if (mem_we) begin
      we_count++;
      check("wr_expected", 32'(exp_wq.size() != 0), 32'd1);
      if (exp_wq.size() != 0) begin
        we_e = exp_wq.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(we_e.addr));
        check("wr_data", mem_data_in, we_e.data);
      end
    end
    if (rd_valid && rd_ready) begin
      pop_count++;
      last_win = win;
      if (first_win < 0) first_win = win;
      check("rd_expected", 32'(exp_rq.size() != 0), 32'd1);
      if (exp_rq.size() != 0) begin
        re_e = exp_rq.pop_front();
        check("rd_data", rd_data, re_e.data);
        check("rd_last", 32'(rd_last), 32'(re_e.last));
      end
    end
    if (done) done_count++;
    @(posedge clk);
    #1;
    win++;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                          input logic [DATA_W-1:0] base, input int gap);
    int w0, d0;
    for (int i = 0; i <= int'(len); i++) begin
      exp_wq.push_back('{addr: ADDR_W'(addr + ADDR_W'(i)), data: base + DATA_W'(i)});
      ref_mem[ADDR_W'(addr + ADDR_W'(i))] = base + DATA_W'(i);
    end
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_len = len;
    cycle();
    req_valid = 1'b0;
    check("wr_ready_busy", 32'(wr_ready), 32'd1);
    check("req_ready_busy", 32'(req_ready), 32'd0);
    w0 = we_count;
    for (int i = 0; i <= int'(len); i++) begin
      wr_valid = 1'b0;
      repeat (gap) cycle();
      wr_valid = 1'b1;
      wr_data  = base + DATA_W'(i);
      cycle();
    end
    wr_valid = 1'b0;
    wr_data  = '0;
    check("we_cycles", 32'(we_count - w0), 32'(int'(len) + 1));
    d0 = done_count;
    cycle();
    check("wr_done_pulse", 32'(done_count - d0), 32'd1);
    check("req_ready_after_wr", 32'(req_ready), 32'd1);
    cycle();
    check("wr_done_single", 32'(done_count - d0), 32'd1);
    check("wr_queue_drained", 32'(exp_wq.size()), 32'd0);
  endtask

  // mode 0: rd_ready held high; mode 1: rd_ready pattern 1,0,0 repeating.
  // abort_pops >= 0 returns early once that many beats have been taken.
  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                         input int mode, input int abort_pops);
    int p0, d0;
    for (int i = 0; i <= int'(len); i++) begin
      exp_rq.push_back('{last: (i == int'(len)), data: ref_mem[ADDR_W'(addr + ADDR_W'(i))]});
    end
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_len = len;
    rd_ready  = 1'b1;
    cycle();
    req_valid = 1'b0;
    check("req_ready_busy", 32'(req_ready), 32'd0);
    win = 0; first_win = -1; last_win = -1;
    p0 = pop_count;
    for (int k = 0; k < 200 && exp_rq.size() != 0 && (pop_count - p0) != abort_pops; k++) begin
      rd_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      cycle();
    end
    if (abort_pops >= 0) return;
    check("rd_all_beats", 32'(exp_rq.size()), 32'd0);
    check("rd_beat_count", 32'(pop_count - p0), 32'(int'(len) + 1));
    if (mode == 0) begin
      check("rd_first_latency", 32'(first_win), 32'd2);
      check("rd_back_to_back", 32'(last_win - first_win), 32'(len));
    end
    rd_ready = 1'b1;
    d0 = done_count;
    cycle();
    check("rd_done_pulse", 32'(done_count - d0), 32'd1);
    check("rd_valid_after", 32'(rd_valid), 32'd0);
    cycle();
    check("rd_done_single", 32'(done_count - d0), 32'd1);
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_burst_en", 32'(mem_burst_enable), 32'd0);
    check("rst_burst_len", 32'(mem_burst_length), 32'd0);
    rst = 1'b0;
    cycle();

    do_write(9'h010, 4'd3, 32'hA0, 0);
    do_read(9'h010, 4'd3, 0, -1);
    do_write(9'h1FE, 4'd3, 32'hC0, 0);
    do_read(9'h1FE, 4'd3, 0, -1);
    do_write(9'h014, 4'd3, 32'hB0, 2);
    do_read(9'h010, 4'd7, 1, -1);

    // Abandon a read after three beats with an asynchronous reset
    do_read(9'h010, 4'd7, 0, 3);
    #2;
    rst = 1'b1;
    #1;
    check("arst_rd_valid", 32'(rd_valid), 32'd0);
    check("arst_rd_last", 32'(rd_last), 32'd0);
    check("arst_rd_data", rd_data, 32'd0);
    check("arst_mem_we", 32'(mem_we), 32'd0);
    check("arst_mem_addr", 32'(mem_addr), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd1);
    check("arst_done", 32'(done), 32'd0);
    exp_rq.delete();
    d0 = done_count;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) cycle();
    check("arst_no_done", 32'(done_count - d0), 32'd0);
    do_read(9'h010, 4'd0, 0, -1);

    check("total_done", 32'(done_count), 32'd7);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
